// File: rtl/fnd_pkg.sv
// rtl/fnd_pkg.sv - shared constants, glyph table and helpers for the FND scanner
//
// Purpose : glyph table, segment-off constant, slot state type and
//           width helper used by fnd_glyph_sel and fnd_scan_ndigit.
// Ports   : none (package).

package fnd_pkg;

  typedef enum logic {
    SLOT_BLANK = 1'b0,
    SLOT_SHOW  = 1'b1
  } slot_state_t;

  // Active-high segment word {a,b,c,d,e,f,g,dp}; all segments dark.
  localparam logic [7:0] SEG_OFF = 8'h00;

  // Entry n is the active-high glyph for hex digit n; dp bit is always 0.
  localparam logic [15:0][7:0] GLYPH_TAB = {
    8'h8E, 8'h9E, 8'h7A, 8'h9C, 8'h3E, 8'hEE, 8'hF6, 8'hFE,
    8'hE0, 8'hBE, 8'hB6, 8'h66, 8'hF2, 8'hDA, 8'h60, 8'hFC
  };

  function automatic logic [7:0] hex_to_seg(input logic [3:0] nibble);
    return GLYPH_TAB[nibble];
  endfunction

  // Bits needed to hold values 0..value-1.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/fnd_glyph_sel.sv
// rtl/fnd_glyph_sel.sv - combinational glyph selection with leading-zero blanking
//
// Purpose : picks the active-high segment word for the digit addressed by idx.
// Ports   : idx      - digit currently scanned
//           hex_in   - nibble k drives digit k (digit 0 rightmost)
//           dp_in    - decimal point per digit
//           digit_en - 1 = digit may light
//           lzb_en   - leading-zero blanking enable
//           glyph    - active-high {a..g,dp}

module fnd_glyph_sel
  import fnd_pkg::*;
#(
  parameter int NUM_DIGITS = 4,
  parameter int IDX_W      = 2
) (
  input  logic [IDX_W-1:0]        idx,
  input  logic [4*NUM_DIGITS-1:0] hex_in,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic [NUM_DIGITS-1:0]   digit_en,
  input  logic                    lzb_en,
  output logic [7:0]              glyph
);

  logic [NUM_DIGITS-1:0] lz_blank;

  // Walk from the most significant digit down; a digit is a leading zero
  // while every digit from the top down to it is zero or disabled.
  always_comb begin
    logic run_zero;
    run_zero = 1'b1;
    lz_blank = '0;
    for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
      run_zero    = run_zero & ((hex_in[4*k +: 4] == 4'h0) | ~digit_en[k]);
      lz_blank[k] = run_zero & (k != 0);
    end
  end

  always_comb begin
    glyph = SEG_OFF;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      if (idx == IDX_W'(k)) begin
        if (!digit_en[k]) begin
          glyph = SEG_OFF;
        end else if (lzb_en && lz_blank[k]) begin
          glyph = {7'b0, dp_in[k]};
        end else begin
          glyph = hex_to_seg(hex_in[4*k +: 4]) | {7'b0, dp_in[k]};
        end
      end
    end
  end

endmodule

// File: rtl/fnd_scan_ndigit.sv
// rtl/fnd_scan_ndigit.sv - N-digit time-multiplexed 7-segment display scanner
//
// Purpose : scans NUM_DIGITS digits, DIV = CLK_HZ/SCAN_HZ cycles per slot,
//           with BLANK_CYCLES all-off cycles at the start of each slot.
//           Optional build macro FND_BRIGHTNESS_EN adds 16-step PWM dimming.
// Ports   : clk        - system clock
//           rst_n      - asynchronous active-low reset
//           hex_in     - nibble k = digit k, digit 0 rightmost
//           dp_in      - decimal point per digit
//           digit_en   - 1 = digit may light
//           lzb_en     - leading-zero blanking enable
//           brightness - PWM level 0..15 (FND_BRIGHTNESS_EN only)
//           seg        - {a,b,c,d,e,f,g,dp}, polarity per SEG_ACTIVE_LOW
//           dig        - one-hot digit select, polarity per DIG_ACTIVE_LOW
//           frame_tick - one-cycle pulse after the last digit's slot ends

module fnd_scan_ndigit
  import fnd_pkg::*;
#(
  parameter int NUM_DIGITS     = 4,
  parameter int CLK_HZ         = 100_000_000,
  parameter int SCAN_HZ        = 960,
  parameter int BLANK_CYCLES   = 16,
  parameter int SEG_ACTIVE_LOW = 0,
  parameter int DIG_ACTIVE_LOW = 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [4*NUM_DIGITS-1:0] hex_in,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic [NUM_DIGITS-1:0]   digit_en,
  input  logic                    lzb_en,
`ifdef FND_BRIGHTNESS_EN
  input  logic [3:0]              brightness,
`endif
  output logic [7:0]              seg,
  output logic [NUM_DIGITS-1:0]   dig,
  output logic                    frame_tick
);

  localparam int DIV   = CLK_HZ / SCAN_HZ;
  localparam int CNT_W = clog2(DIV);
  localparam int IDX_W = (NUM_DIGITS > 1) ? clog2(NUM_DIGITS) : 1;

  localparam logic [CNT_W-1:0] SLOT_LAST = CNT_W'(DIV - 1);
  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(NUM_DIGITS - 1);

  // XOR masks that turn active-high internal words into pin polarity;
  // they are also the "everything off" pin values.
  localparam logic [7:0] SEG_IDLE = (SEG_ACTIVE_LOW != 0) ? ~SEG_OFF : SEG_OFF;
  localparam logic [NUM_DIGITS-1:0] DIG_OFF =
    (DIG_ACTIVE_LOW != 0) ? {NUM_DIGITS{1'b1}} : {NUM_DIGITS{1'b0}};

  logic [CNT_W-1:0]      slot_cnt;
  logic [IDX_W-1:0]      idx;
  slot_state_t           state;
  logic                  slot_wrap;
  logic                  pwm_on;
  logic [7:0]            glyph;
  logic [7:0]            seg_next;
  logic [NUM_DIGITS-1:0] dig_next;

  fnd_glyph_sel #(
    .NUM_DIGITS (NUM_DIGITS),
    .IDX_W      (IDX_W)
  ) u_glyph_sel (
    .idx      (idx),
    .hex_in   (hex_in),
    .dp_in    (dp_in),
    .digit_en (digit_en),
    .lzb_en   (lzb_en),
    .glyph    (glyph)
  );

`ifdef FND_BRIGHTNESS_EN
  logic [3:0] pwm_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) pwm_cnt <= 4'd0;
    else        pwm_cnt <= pwm_cnt + 4'd1;
  end

  assign pwm_on = (pwm_cnt <= brightness);
`else
  assign pwm_on = 1'b1;
`endif

  assign slot_wrap = (slot_cnt == SLOT_LAST);

  // Slot phase is a pure decode of slot_cnt; outputs for the next cycle.
  always_comb begin
    state    = (int'(slot_cnt) < BLANK_CYCLES) ? SLOT_BLANK : SLOT_SHOW;
    seg_next = SEG_OFF;
    dig_next = '0;
    if (state == SLOT_SHOW && pwm_on) begin
      seg_next = glyph;
      for (int k = 0; k < NUM_DIGITS; k++) begin
        dig_next[k] = (idx == IDX_W'(k));
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slot_cnt   <= '0;
      idx        <= '0;
      frame_tick <= 1'b0;
      seg        <= SEG_IDLE;
      dig        <= DIG_OFF;
    end else begin
      slot_cnt   <= slot_wrap ? '0 : slot_cnt + CNT_W'(1);
      if (slot_wrap) begin
        idx <= (idx == IDX_LAST) ? '0 : idx + IDX_W'(1);
      end
      frame_tick <= slot_wrap && (idx == IDX_LAST);
      seg        <= seg_next ^ SEG_IDLE;
      dig        <= dig_next ^ DIG_OFF;
    end
  end

endmodule

// File: tb/tb_fnd_scan_ndigit.sv
// tb/tb_fnd_scan_ndigit.sv - self-checking bench for fnd_scan_ndigit

module tb_fnd_scan_ndigit;

  localparam int N     = 4;
  localparam int DIV   = 10;
  localparam int BLANK = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] hex_in = 16'h0;
  logic [3:0]  dp_in = 4'h0;
  logic [3:0]  digit_en = 4'hF;
  logic        lzb_en = 1'b0;
  logic [7:0]  seg;
  logic [3:0]  dig;
  logic        frame_tick;
`ifdef FND_BRIGHTNESS_EN
  logic [3:0]  brightness = 4'd15;
`endif

  int n_cmp = 0;
  int n_bad = 0;
  int m_slot = 0;
  int m_idx = 0;
  int m_pwm = 0;
  logic [12:0] exp_q[$];
  logic [12:0] exp_v;
  logic [12:0] obs_v;

  fnd_scan_ndigit #(
    .NUM_DIGITS     (N),
    .CLK_HZ         (1000),
    .SCAN_HZ        (100),
    .BLANK_CYCLES   (BLANK),
    .SEG_ACTIVE_LOW (0),
    .DIG_ACTIVE_LOW (1)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .hex_in     (hex_in),
    .dp_in      (dp_in),
    .digit_en   (digit_en),
    .lzb_en     (lzb_en),
`ifdef FND_BRIGHTNESS_EN
    .brightness (brightness),
`endif
    .seg        (seg),
    .dig        (dig),
    .frame_tick (frame_tick)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] ref_glyph(input logic [3:0] n);
    case (n)
      4'h0: return 8'hFC;  4'h1: return 8'h60;  4'h2: return 8'hDA;  4'h3: return 8'hF2;
      4'h4: return 8'h66;  4'h5: return 8'hB6;  4'h6: return 8'hBE;  4'h7: return 8'hE0;
      4'h8: return 8'hFE;  4'h9: return 8'hF6;  4'hA: return 8'hEE;  4'hB: return 8'h3E;
      4'hC: return 8'h9C;  4'hD: return 8'h7A;  4'hE: return 8'h9E;  default: return 8'h8E;
    endcase
  endfunction

  // Expected {frame_tick, dig, seg} after the coming edge, from the current
  // inputs and the bench's own slot/digit counters; then advance the counters.
  task automatic push_expected();
    logic [7:0] s;
    logic [3:0] d;
    logic       ft, blanked, on;
    s  = 8'h00;
    d  = 4'hF;
    on = 1'b1;
`ifdef FND_BRIGHTNESS_EN
    on    = (m_pwm <= int'(brightness));
    m_pwm = (m_pwm + 1) % 16;
`endif
    if (m_slot >= BLANK && on) begin
      d = ~(4'b0001 << m_idx);
      blanked = lzb_en && (m_idx != 0);
      for (int i = m_idx; i < N; i++) begin
        if (hex_in[4*i +: 4] != 4'h0 && digit_en[i]) blanked = 1'b0;
      end
      if (!digit_en[m_idx])  s = 8'h00;
      else if (blanked)      s = {7'b0, dp_in[m_idx]};
      else                   s = ref_glyph(hex_in[4*m_idx +: 4]) | {7'b0, dp_in[m_idx]};
    end
    ft = (m_slot == DIV - 1) && (m_idx == N - 1);
    exp_q.push_back({ft, d, s});
    if (m_slot == DIV - 1) begin
      m_slot = 0;
      m_idx  = (m_idx + 1) % N;
    end else begin
      m_slot++;
    end
  endtask

  task automatic model_reset();
    m_slot = 0;
    m_idx  = 0;
    m_pwm  = 0;
    exp_q.delete();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    n_cmp++;
    if ({frame_tick, dig, seg} !== {1'b0, 4'hF, 8'h00}) begin
      n_bad++;
      $display("FAIL reset_state: got ft/dig/seg=%h want %h", {frame_tick, dig, seg}, {1'b0, 4'hF, 8'h00});
    end
    rst_n = 1'b1;
    model_reset();
  endtask

  task automatic test_scan_order();
    int ticks;
    ticks    = 0;
    hex_in   = 16'h1234;
    digit_en = 4'hF;
    dp_in    = 4'h0;
    lzb_en   = 1'b0;
    for (int i = 1; i <= 80; i++) begin
      push_expected();
      @(negedge clk);
      exp_v = exp_q.pop_front();
      obs_v = {frame_tick, dig, seg};
      n_cmp++;
      if (obs_v !== exp_v) begin
        n_bad++;
        $display("FAIL scan cyc%0d: got %h want %h", i, obs_v, exp_v);
      end
      if (frame_tick) ticks++;
      if (i == 1 || i == 2 || i == 3 || i == 13 || i == 23 || i == 33) begin
        logic [11:0] want;
        case (i)
          1, 2:    want = {4'hF, 8'h00};
          3:       want = {4'hE, 8'h66};
          13:      want = {4'hD, 8'hF2};
          23:      want = {4'hB, 8'hDA};
          default: want = {4'h7, 8'h60};
        endcase
        n_cmp++;
        if ({dig, seg} !== want) begin
          n_bad++;
          $display("FAIL scan_fixed cyc%0d: got %h want %h", i, {dig, seg}, want);
        end
      end
    end
    n_cmp++;
    if (ticks != 2) begin
      n_bad++;
      $display("FAIL frame_tick_count: got %0d want 2", ticks);
    end
  endtask

  task automatic test_lzb();
    lzb_en = 1'b1;
    for (int pass = 0; pass < 2; pass++) begin
      hex_in = (pass == 0) ? 16'h0050 : 16'h0000;
      for (int i = 1; i <= 40; i++) begin
        logic [7:0] want;
        push_expected();
        @(negedge clk);
        exp_v = exp_q.pop_front();
        obs_v = {frame_tick, dig, seg};
        n_cmp++;
        if (obs_v !== exp_v) begin
          n_bad++;
          $display("FAIL lzb p%0d cyc%0d: got %h want %h", pass, i, obs_v, exp_v);
        end
        if (dig != 4'hF) begin
          want = 8'h00;
          if (dig == 4'hE) want = 8'hFC;
          if (dig == 4'hD && pass == 0) want = 8'hB6;
          n_cmp++;
          if (seg !== want) begin
            n_bad++;
            $display("FAIL lzb_glyph p%0d dig=%h: got %h want %h", pass, dig, seg, want);
          end
        end
      end
    end
  endtask

  task automatic test_enable_dp();
    int on0, on2;
    on0      = 0;
    on2      = 0;
    lzb_en   = 1'b0;
    digit_en = 4'b1010;
    dp_in    = 4'b0010;
    hex_in   = 16'h8888;
    for (int i = 1; i <= 40; i++) begin
      logic [7:0] want;
      push_expected();
      @(negedge clk);
      exp_v = exp_q.pop_front();
      obs_v = {frame_tick, dig, seg};
      n_cmp++;
      if (obs_v !== exp_v) begin
        n_bad++;
        $display("FAIL en_dp cyc%0d: got %h want %h", i, obs_v, exp_v);
      end
      if (dig == 4'hE) on0++;
      if (dig == 4'hB) on2++;
      if (dig != 4'hF) begin
        want = (dig == 4'hD) ? 8'hFF : (dig == 4'h7) ? 8'hFE : 8'h00;
        n_cmp++;
        if (seg !== want) begin
          n_bad++;
          $display("FAIL en_dp_glyph dig=%h: got %h want %h", dig, seg, want);
        end
      end
    end
    n_cmp++;
    if (on0 != 8 || on2 != 8) begin
      n_bad++;
      $display("FAIL disabled_dig_time: got %0d/%0d want 8/8", on0, on2);
    end
    digit_en = 4'hF;
    dp_in    = 4'h0;
  endtask

  task automatic test_live_update();
    int guard;
    guard  = 0;
    hex_in = 16'h0001;
    while (!(m_idx == 0 && m_slot == 5) && guard < 100) begin
      push_expected();
      @(negedge clk);
      exp_v = exp_q.pop_front();
      obs_v = {frame_tick, dig, seg};
      n_cmp++;
      if (obs_v !== exp_v) begin
        n_bad++;
        $display("FAIL live_pre: got %h want %h", obs_v, exp_v);
      end
      guard++;
    end
    hex_in = 16'h0007;
    #1;
    n_cmp++;
    if ({dig, seg} !== {4'hE, 8'h60}) begin
      n_bad++;
      $display("FAIL live_before: got %h want %h", {dig, seg}, {4'hE, 8'h60});
    end
    push_expected();
    @(negedge clk);
    exp_v = exp_q.pop_front();
    n_cmp++;
    if ({frame_tick, dig, seg} !== exp_v || seg !== 8'hE0) begin
      n_bad++;
      $display("FAIL live_after: got %h want %h (seg E0)", {frame_tick, dig, seg}, exp_v);
    end
  endtask

  task automatic test_async_reset();
    int guard;
    guard  = 0;
    hex_in = 16'h1234;
    while (!(m_idx == 2 && m_slot == 5) && guard < 100) begin
      push_expected();
      @(negedge clk);
      exp_v = exp_q.pop_front();
      obs_v = {frame_tick, dig, seg};
      n_cmp++;
      if (obs_v !== exp_v) begin
        n_bad++;
        $display("FAIL areset_pre: got %h want %h", obs_v, exp_v);
      end
      guard++;
    end
    n_cmp++;
    if (dig !== 4'hB || seg !== 8'hDA) begin
      n_bad++;
      $display("FAIL areset_lit: got %h want %h", {dig, seg}, {4'hB, 8'hDA});
    end
    #1 rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({frame_tick, dig, seg} !== {1'b0, 4'hF, 8'h00}) begin
      n_bad++;
      $display("FAIL areset_off: got %h want %h", {frame_tick, dig, seg}, {1'b0, 4'hF, 8'h00});
    end
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    for (int i = 1; i <= 12; i++) begin
      push_expected();
      @(negedge clk);
      exp_v = exp_q.pop_front();
      obs_v = {frame_tick, dig, seg};
      n_cmp++;
      if (obs_v !== exp_v) begin
        n_bad++;
        $display("FAIL areset_post cyc%0d: got %h want %h", i, obs_v, exp_v);
      end
      if (i == 2 || i == 3) begin
        n_cmp++;
        if (dig !== ((i == 2) ? 4'hF : 4'hE)) begin
          n_bad++;
          $display("FAIL areset_restart cyc%0d: got dig %h", i, dig);
        end
      end
    end
  endtask

`ifdef FND_BRIGHTNESS_EN
  task automatic test_brightness();
    for (int pass = 0; pass < 2; pass++) begin
      brightness = (pass == 0) ? 4'd3 : 4'd15;
      for (int i = 1; i <= 80; i++) begin
        push_expected();
        @(negedge clk);
        exp_v = exp_q.pop_front();
        obs_v = {frame_tick, dig, seg};
        n_cmp++;
        if (obs_v !== exp_v) begin
          n_bad++;
          $display("FAIL brightness p%0d cyc%0d: got %h want %h", pass, i, obs_v, exp_v);
        end
      end
    end
  endtask
`endif

  initial begin
    @(negedge clk);
    test_reset();
    test_scan_order();
    test_lzb();
    test_enable_dp();
    test_live_update();
    test_async_reset();
`ifdef FND_BRIGHTNESS_EN
    test_brightness();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
